// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: MIPS opcodes,
// forwarding-select encodings and the sequencing FSM states.
package hazard_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hazard_state_t;

    // Instructions whose rt field is a source operand rather than a destination.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// Forwarding select for one EX operand; the EX/MEM result is newer than
// MEM/WB so it takes priority, and register 0 is never forwarded.
module forward_sel
    import hazard_defs::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src_reg,
    input  logic            exmem_write,
    input  logic [RA_W-1:0] exmem_reg,
    input  logic            memwb_write,
    input  logic [RA_W-1:0] memwb_reg,
    output logic [1:0]      sel
);

    always_comb begin
        sel = FWD_RF;
        if (exmem_write && (exmem_reg != '0) && (exmem_reg == src_reg)) begin
            sel = FWD_EXMEM;
        end else if (memwb_write && (memwb_reg != '0) && (memwb_reg == src_reg)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller: load-use stalls, taken-branch flushes,
// EX operand forwarding selects and saturating hazard statistics.
module pipeline_hazard_ctrl
    import hazard_defs::*;
#(
    parameter int CNT_W = 16,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ifidInstr,
    input  logic [31:0]      idexInstr,
    input  logic             idexMemRead,
    input  logic             branchTaken,
    input  logic             exmemRegWrite,
    input  logic [RA_W-1:0]  exmemWriteReg,
    input  logic             memwbRegWrite,
    input  logic [RA_W-1:0]  memwbWriteReg,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             idexBubble,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    hazard_state_t state, next_state;

    logic [5:0] ifid_op;
    logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt;
    logic       load_use, stall_req;
    logic [1:0] fwd_a, fwd_b;
    logic       unused_fields;

    assign ifid_op = ifidInstr[31:26];
    assign ifid_rs = ifidInstr[25:21];
    assign ifid_rt = ifidInstr[20:16];
    assign idex_rs = idexInstr[25:21];
    assign idex_rt = idexInstr[20:16];
    assign unused_fields = ^{ifidInstr[15:0], idexInstr[31:26], idexInstr[15:0]};

    assign load_use = idexMemRead && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (uses_rt(ifid_op) && (idex_rt == ifid_rt)));

    // A stall is only honoured from RUN, and a taken branch always overrides it.
    assign stall_req = (state == ST_RUN) && load_use && !branchTaken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = ST_RUN;
        if (branchTaken) begin
            next_state = ST_FLUSH;
        end else if (state == ST_RUN && load_use) begin
            next_state = ST_STALL;
        end
    end

    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        idexBubble = 1'b0;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        forwardA   = fwd_a;
        forwardB   = fwd_b;
        if (reset) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
            forwardA   = FWD_RF;
            forwardB   = FWD_RF;
        end else if (branchTaken) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (stall_req) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (stall_req && (stallCount != '1)) begin
                stallCount <= stallCount + CNT_W'(1);
            end
            if (branchTaken && (flushCount != '1)) begin
                flushCount <= flushCount + CNT_W'(1);
            end
        end
    end

    forward_sel #(.RA_W(RA_W)) u_fwd_a (
        .src_reg     (RA_W'(idex_rs)),
        .exmem_write (exmemRegWrite),
        .exmem_reg   (exmemWriteReg),
        .memwb_write (memwbRegWrite),
        .memwb_reg   (memwbWriteReg),
        .sel         (fwd_a)
    );

    forward_sel #(.RA_W(RA_W)) u_fwd_b (
        .src_reg     (RA_W'(idex_rt)),
        .exmem_write (exmemRegWrite),
        .exmem_reg   (exmemWriteReg),
        .memwb_write (memwbRegWrite),
        .memwb_reg   (memwbWriteReg),
        .sel         (fwd_b)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench for pipeline_hazard_ctrl; a narrow-counter
// second instance shares the stimulus so counter saturation is reachable quickly.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ifidInstr, idexInstr;
    logic        idexMemRead, branchTaken, exmemRegWrite, memwbRegWrite;
    logic [4:0]  exmemWriteReg, memwbWriteReg;

    logic        pcWrite, ifidWrite, idexBubble, ifidFlush, idexFlush;
    logic [1:0]  forwardA, forwardB;
    logic [15:0] stallCount, flushCount;

    logic        sPcWrite, sIfidWrite, sIdexBubble, sIfidFlush, sIdexFlush;
    logic [1:0]  sForwardA, sForwardB;
    logic [3:0]  sStallCount, sFlushCount;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: "masked" is true for the cycle after any stall or flush,
    // and the counters hold true event totals that are clipped on comparison.
    bit masked = 1'b0;
    int stallEvents = 0;
    int flushEvents = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16), .RA_W(5)) dut (
        .clk(clk), .reset(reset), .ifidInstr(ifidInstr), .idexInstr(idexInstr),
        .idexMemRead(idexMemRead), .branchTaken(branchTaken),
        .exmemRegWrite(exmemRegWrite), .exmemWriteReg(exmemWriteReg),
        .memwbRegWrite(memwbRegWrite), .memwbWriteReg(memwbWriteReg),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexBubble(idexBubble),
        .ifidFlush(ifidFlush), .idexFlush(idexFlush),
        .forwardA(forwardA), .forwardB(forwardB),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    pipeline_hazard_ctrl #(.CNT_W(4), .RA_W(5)) dutSmall (
        .clk(clk), .reset(reset), .ifidInstr(ifidInstr), .idexInstr(idexInstr),
        .idexMemRead(idexMemRead), .branchTaken(branchTaken),
        .exmemRegWrite(exmemRegWrite), .exmemWriteReg(exmemWriteReg),
        .memwbRegWrite(memwbRegWrite), .memwbWriteReg(memwbWriteReg),
        .pcWrite(sPcWrite), .ifidWrite(sIfidWrite), .idexBubble(sIdexBubble),
        .ifidFlush(sIfidFlush), .idexFlush(sIdexFlush),
        .forwardA(sForwardA), .forwardB(sForwardB),
        .stallCount(sStallCount), .flushCount(sFlushCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] mkInstr(input int op, input int rs, input int rt, input int rd);
        logic [31:0] w;
        w = '0;
        w[31:26] = op[5:0];
        w[25:21] = rs[4:0];
        w[20:16] = rt[4:0];
        w[15:11] = rd[4:0];
        return w;
    endfunction

    function automatic int sat(input int n, input int w);
        int top;
        top = (1 << w) - 1;
        return (n > top) ? top : n;
    endfunction

    function automatic logic [1:0] fwdModel(input logic [4:0] src, input logic exw, input logic [4:0] exr,
                                            input logic mww, input logic [4:0] mwr);
        if (exw && exr != 0 && exr == src) return 2'b10;
        if (mww && mwr != 0 && mwr == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic checkResetOutputs();
        checkOutput("rst_pcWrite", pcWrite, 0);
        checkOutput("rst_ifidWrite", ifidWrite, 0);
        checkOutput("rst_bubble", idexBubble, 1);
        checkOutput("rst_ifidFlush", ifidFlush, 1);
        checkOutput("rst_idexFlush", idexFlush, 1);
        checkOutput("rst_fwdA", forwardA, 0);
        checkOutput("rst_fwdB", forwardB, 0);
        checkOutput("rst_stallCnt", stallCount, 0);
        checkOutput("rst_flushCnt", flushCount, 0);
        checkOutput("rst_sStallCnt", sStallCount, 0);
    endtask

    // Called just after a rising edge: drives one cycle, checks at the falling edge,
    // then advances the model across the next rising edge.
    task automatic applyStimulus(input logic [31:0] fi, input logic [31:0] di, input logic mr, input logic bt,
                                 input logic exw, input logic [4:0] exr, input logic mww, input logic [4:0] mwr);
        logic [5:0] op;
        logic [4:0] frs, frt, drs, drt;
        logic       usesRt, lu, stall;
        ifidInstr = fi; idexInstr = di; idexMemRead = mr; branchTaken = bt;
        exmemRegWrite = exw; exmemWriteReg = exr; memwbRegWrite = mww; memwbWriteReg = mwr;
        @(negedge clk);
        op = fi[31:26]; frs = fi[25:21]; frt = fi[20:16]; drs = di[25:21]; drt = di[20:16];
        usesRt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
        lu = mr && (drt != 0) && ((drt == frs) || (usesRt && drt == frt));
        stall = !masked && lu && !bt;
        checkOutput("pcWrite", pcWrite, !stall);
        checkOutput("ifidWrite", ifidWrite, !stall);
        checkOutput("idexBubble", idexBubble, stall);
        checkOutput("ifidFlush", ifidFlush, bt);
        checkOutput("idexFlush", idexFlush, bt);
        checkOutput("forwardA", forwardA, fwdModel(drs, exw, exr, mww, mwr));
        checkOutput("forwardB", forwardB, fwdModel(drt, exw, exr, mww, mwr));
        checkOutput("stallCount", stallCount, sat(stallEvents, 16));
        checkOutput("flushCount", flushCount, sat(flushEvents, 16));
        checkOutput("sStallCount", sStallCount, sat(stallEvents, 4));
        checkOutput("sFlushCount", sFlushCount, sat(flushEvents, 4));
        @(posedge clk);
        if (stall) stallEvents++;
        if (bt) flushEvents++;
        masked = stall || bt;
        #1;
    endtask

    task automatic idle();
        applyStimulus(32'h0, 32'h0, 0, 0, 0, 5'd0, 0, 5'd0);
    endtask

    initial begin : mainSeq
        logic [31:0] lw2, add423, stallRef;
        int ops[6];
        ops = '{'h00, 'h23, 'h2B, 'h04, 'h05, 'h08};
        lw2    = mkInstr('h23, 1, 2, 0);
        add423 = mkInstr('h00, 2, 3, 4);

        reset = 1'b0;
        ifidInstr = '0; idexInstr = '0; idexMemRead = 0; branchTaken = 0;
        exmemRegWrite = 0; exmemWriteReg = '0; memwbRegWrite = 0; memwbWriteReg = '0;
        #1 reset = 1'b1;
        #2 checkResetOutputs();
        @(posedge clk); @(posedge clk); #1;
        checkResetOutputs();
        reset = 1'b0;

        // Load-use on rs: one stall cycle, then masked.
        applyStimulus(add423, lw2, 1, 0, 0, 5'd0, 0, 5'd0);
        applyStimulus(add423, lw2, 1, 0, 0, 5'd0, 0, 5'd0);
        checkOutput("stallCnt_after_lw", stallCount, 1);
        idle();
        // addi: rt is a destination, only rs can trigger; load to $0 never stalls.
        applyStimulus(mkInstr('h08, 3, 2, 0), lw2, 1, 0, 0, 5'd0, 0, 5'd0);
        applyStimulus(mkInstr('h08, 2, 5, 0), lw2, 1, 0, 0, 5'd0, 0, 5'd0);
        idle();
        applyStimulus(mkInstr('h00, 0, 0, 4), mkInstr('h23, 1, 0, 0), 1, 0, 0, 5'd0, 0, 5'd0);
        // Forwarding priority and register-0 exclusion.
        applyStimulus(32'h0, mkInstr('h00, 7, 3, 0), 0, 0, 1, 5'd7, 1, 5'd7);
        checkOutput("fwdA_exmem", forwardA, 2'b10);
        applyStimulus(32'h0, mkInstr('h00, 7, 3, 0), 0, 0, 0, 5'd7, 1, 5'd7);
        applyStimulus(32'h0, mkInstr('h00, 0, 0, 0), 0, 0, 1, 5'd0, 1, 5'd0);
        // Branch beats load-use, and load-use is masked the cycle after.
        applyStimulus(add423, lw2, 1, 1, 0, 5'd0, 0, 5'd0);
        applyStimulus(add423, lw2, 1, 0, 0, 5'd0, 0, 5'd0);
        checkOutput("flushCnt_after_br", flushCount, 1);
        idle();

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(mkInstr(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
                          mkInstr(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
        end
        checkOutput("sStall_saturated", sStallCount, 4'hF);

        // Reset in the middle of a stall.
        idle();
        stallRef = add423;
        applyStimulus(stallRef, lw2, 1, 0, 0, 5'd0, 0, 5'd0);
        #2 reset = 1'b1;
        #1 checkResetOutputs();
        @(posedge clk); #1;
        checkResetOutputs();
        reset = 1'b0;
        masked = 1'b0; stallEvents = 0; flushEvents = 0;
        applyStimulus(stallRef, lw2, 1, 0, 0, 5'd0, 0, 5'd0);
        idle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and forwarding controller for the 5-stage MIPS pipeline. It consumes the ID/EX register outputs (registered instruction, memory-read control) plus the EX/MEM and MEM/WB destination info. It drives stall, bubble and flush controls back into PC, IF/ID and ID/EX, and forwarding selects into the EX operand muxes. Small FSM sequences load-use stalls and branch flushes; saturating counters expose hazard statistics.

Parameters:
CNT_W, 16, width of stall/flush statistic counters
RA_W, 5, register address width

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
ifidInstr  in  32  instruction currently in IF/ID
idexInstr  in  32  instruction currently in ID/EX (instrOut of ID/EX)
idexMemRead  in  1  ID/EX instruction is a load
branchTaken  in  1  EX resolved a taken branch/jump this cycle
exmemRegWrite  in  1  EX/MEM writes a register
exmemWriteReg  in  RA_W  EX/MEM destination register
memwbRegWrite  in  1  MEM/WB writes a register
memwbWriteReg  in  RA_W  MEM/WB destination register
pcWrite  out  1  PC update enable
ifidWrite  out  1  IF/ID load enable
idexBubble  out  1  zero ID/EX control fields next edge (stall bubble)
ifidFlush  out  1  clear IF/ID next edge
idexFlush  out  1  clear ID/EX next edge
forwardA  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
forwardB  out  2  EX operand B select, same encoding
stallCount  out  CNT_W  saturating count of stall cycles
flushCount  out  CNT_W  saturating count of flush events

Behaviour:
- Field decode: rs=[25:21], rt=[20:16], op=[31:26]. IF/ID "uses rt" when op is 0x00, 0x2B (sw), 0x04 (beq) or 0x05 (bne).
- loadUse (comb) = idexMemRead & idexRt!=0 & (idexRt==ifidRs | (usesRt & idexRt==ifidRt)).
- FSM states RUN, STALL, FLUSH; reset -> RUN.
- RUN: branchTaken -> FLUSH; else loadUse -> STALL; else stay RUN.
- STALL and FLUSH: unconditionally return to RUN after one cycle, except branchTaken -> FLUSH. loadUse is masked in both states.
- Outputs are combinational from state and inputs, evaluated in the current cycle:
  - branchTaken in any state: ifidFlush=1, idexFlush=1, pcWrite=1, ifidWrite=1, idexBubble=0.
  - RUN & loadUse & !branchTaken: pcWrite=0, ifidWrite=0, idexBubble=1.
  - Otherwise: pcWrite=1, ifidWrite=1, bubble and flushes 0.
- Simultaneous branchTaken and loadUse: branch wins; no stall, no stallCount increment.
- Forwarding, for A using idexRs and B using idexRt:
  - 10 if exmemRegWrite & exmemWriteReg!=0 & match.
  - Else 01 if memwbRegWrite & memwbWriteReg!=0 & match.
  - Else 00. EX/MEM has priority. Register 0 never forwards.
- Counters:
  - stallCount +1 on each edge where a stall was asserted.
  - flushCount +1 on each edge where branchTaken=1.
  - Both saturate at all-ones, with no wrap.
- Reset asserted (async, immediate): state=RUN, counters=0; pcWrite=0, ifidWrite=0, idexBubble=1, ifidFlush=1, idexFlush=1, forwardA=forwardB=00. Outputs resume normal values in the first cycle after reset deasserts.
- Reset mid-stall aborts the stall; no counter update occurs on that edge.

Decomposition:
- Shared package (hazard_defs): opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE), forward-select encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB), FSM state encodings.
- One sub-module, forward_sel: pure combinational select for one operand, instantiated twice.

Test Plan:
- lw $2 in ID/EX (idexMemRead=1, rt=2), add $4,$2,$3 in IF/ID -> one cycle pcWrite=0, ifidWrite=0, idexBubble=1; next cycle all normal; stallCount=1.
- lw $2 in ID/EX, addi $5,$2,1 (op 0x08, rt=5 dest only): rt match with rt=2 alternative -> no stall; only rs=2 triggers. Load to $0 -> never stalls.
- exmemWriteReg=7 and memwbWriteReg=7 (both RegWrite), idex rs=7 -> forwardA=10. With exmemRegWrite=0 -> forwardA=01. Dest 0 -> 00.
- branchTaken=1 with loadUse also true -> ifidFlush=idexFlush=1, pcWrite=1, no bubble; flushCount=1, stallCount unchanged. Next cycle loadUse is masked.
- Preload counters by forcing 65535 stall cycles -> stallCount=0xFFFF; a further stall leaves it at 0xFFFF.
- Assert reset during STALL -> outputs go to reset values immediately; after release state=RUN, counters=0.
